// File: rtl/sja1000_bus_master_if.sv
// Bundle of the request handshake and the SJA1000 Intel-mode bus pins.
// The master modport is the sequencer; the slave modport is its environment.
interface sja1000_bus_master_if;
    logic       req;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       sja_ale;
    logic       sja_csn;
    logic       sja_wrn;
    logic       sja_rdn;
    logic [7:0] sja_ad_out;
    logic       sja_ad_oe;
    logic [7:0] sja_ad_in;
    logic       sja_intn;
    logic       int_o;

    modport master (
        input  req, req_wr, req_addr, req_wdata, sja_ad_in, sja_intn,
        output busy, done, rdata, sja_ale, sja_csn, sja_wrn, sja_rdn,
               sja_ad_out, sja_ad_oe, int_o
    );

    modport slave (
        output req, req_wr, req_addr, req_wdata, sja_ad_in, sja_intn,
        input  busy, done, rdata, sja_ale, sja_csn, sja_wrn, sja_rdn,
               sja_ad_out, sja_ad_oe, int_o
    );
endinterface

// File: rtl/sja1000_bus_master.sv
// Intel-mode multiplexed-bus sequencer for the SJA1000 CAN controller: one byte
// read or write per request, with the interrupt line synchronised alongside.
module sja1000_bus_master #(
    parameter int unsigned T_ALE = 2,
    parameter int unsigned T_AH  = 1,
    parameter int unsigned T_STB = 4,
    parameter int unsigned T_HLD = 1,
    parameter int unsigned T_REC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sja1000_bus_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ALE  = 3'd1,
        S_AH   = 3'd2,
        S_STB  = 3'd3,
        S_HLD  = 3'd4,
        S_REC  = 3'd5
    } state_t;

    localparam logic [3:0] LD_ALE = 4'(T_ALE - 1);
    localparam logic [3:0] LD_AH  = 4'(T_AH - 1);
    localparam logic [3:0] LD_STB = 4'(T_STB - 1);
    localparam logic [3:0] LD_HLD = 4'(T_HLD - 1);
    localparam logic [3:0] LD_REC = 4'(T_REC - 1);

    state_t     state_r, state_nxt_s;
    logic [3:0] cnt_r, cnt_nxt_s;
    logic       wr_r, wr_nxt_s;
    logic [7:0] addr_r, addr_nxt_s;
    logic [7:0] wdata_r, wdata_nxt_s;
    logic [7:0] ad_q_r;
    logic [7:0] rdata_r, rdata_nxt_s;
    logic       done_r, done_nxt_s;
    logic       busy_r;
    logic       ale_r, ale_nxt_s;
    logic       csn_r, csn_nxt_s;
    logic       wrn_r, wrn_nxt_s;
    logic       rdn_r, rdn_nxt_s;
    logic       oe_r, oe_nxt_s;
    logic [7:0] ad_out_r, ad_out_nxt_s;
    logic       int_meta_r, int_r;

    // Phase sequencing: each phase reloads the counter and leaves when it reaches zero.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        wr_nxt_s    = wr_r;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        rdata_nxt_s = rdata_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.req) begin
                    state_nxt_s = S_ALE;
                    cnt_nxt_s   = LD_ALE;
                    wr_nxt_s    = bus.req_wr;
                    addr_nxt_s  = bus.req_addr;
                    wdata_nxt_s = bus.req_wdata;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ALE: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = S_AH;
                    cnt_nxt_s   = LD_AH;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            S_AH: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = S_STB;
                    cnt_nxt_s   = LD_STB;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            S_STB: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = S_HLD;
                    cnt_nxt_s   = LD_HLD;
                    // ad_q_r was sampled one edge earlier, still inside the strobe window
                    if (wr_r) begin
                        rdata_nxt_s = rdata_r;
                    end else begin
                        rdata_nxt_s = ad_q_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            S_HLD: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = S_REC;
                    cnt_nxt_s   = LD_REC;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            S_REC: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = 4'd0;
                    done_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Pin values for the upcoming phase, so every pin comes straight from a flop.
    always_comb begin
        ale_nxt_s    = 1'b0;
        csn_nxt_s    = 1'b1;
        wrn_nxt_s    = 1'b1;
        rdn_nxt_s    = 1'b1;
        oe_nxt_s     = 1'b0;
        ad_out_nxt_s = ad_out_r;
        case (state_nxt_s)
            S_ALE: begin
                ale_nxt_s    = 1'b1;
                oe_nxt_s     = 1'b1;
                ad_out_nxt_s = addr_nxt_s;
            end
            S_AH: begin
                oe_nxt_s     = 1'b1;
                ad_out_nxt_s = addr_nxt_s;
            end
            S_STB: begin
                csn_nxt_s = 1'b0;
                if (wr_nxt_s) begin
                    wrn_nxt_s    = 1'b0;
                    oe_nxt_s     = 1'b1;
                    ad_out_nxt_s = wdata_nxt_s;
                end else begin
                    rdn_nxt_s = 1'b0;
                    oe_nxt_s  = 1'b0;
                end
            end
            S_HLD: begin
                csn_nxt_s = 1'b0;
                if (wr_nxt_s) begin
                    oe_nxt_s     = 1'b1;
                    ad_out_nxt_s = wdata_nxt_s;
                end else begin
                    oe_nxt_s = 1'b0;
                end
            end
            S_REC, S_IDLE: begin
                ad_out_nxt_s = ad_out_r;
            end
            default: begin
                ad_out_nxt_s = ad_out_r;
            end
        endcase
    end

    // Sequencer state, captured request and registered bus pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            cnt_r    <= 4'd0;
            wr_r     <= 1'b0;
            addr_r   <= 8'h00;
            wdata_r  <= 8'h00;
            rdata_r  <= 8'h00;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            ale_r    <= 1'b0;
            csn_r    <= 1'b1;
            wrn_r    <= 1'b1;
            rdn_r    <= 1'b1;
            oe_r     <= 1'b0;
            ad_out_r <= 8'h00;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            wr_r     <= wr_nxt_s;
            addr_r   <= addr_nxt_s;
            wdata_r  <= wdata_nxt_s;
            rdata_r  <= rdata_nxt_s;
            done_r   <= done_nxt_s;
            busy_r   <= (state_nxt_s != S_IDLE);
            ale_r    <= ale_nxt_s;
            csn_r    <= csn_nxt_s;
            wrn_r    <= wrn_nxt_s;
            rdn_r    <= rdn_nxt_s;
            oe_r     <= oe_nxt_s;
            ad_out_r <= ad_out_nxt_s;
        end
    end

    // AD pad sample register and two-flop interrupt synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_q_r     <= 8'h00;
            int_meta_r <= 1'b0;
            int_r      <= 1'b0;
        end else begin
            ad_q_r     <= bus.sja_ad_in;
            int_meta_r <= ~bus.sja_intn;
            int_r      <= int_meta_r;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.rdata      = rdata_r;
    assign bus.sja_ale    = ale_r;
    assign bus.sja_csn    = csn_r;
    assign bus.sja_wrn    = wrn_r;
    assign bus.sja_rdn    = rdn_r;
    assign bus.sja_ad_out = ad_out_r;
    assign bus.sja_ad_oe  = oe_r;
    assign bus.int_o      = int_r;
endmodule

// File: tb/tb_sja1000_bus_master.sv
// Directed bench for sja1000_bus_master: default-timing instance plus a
// T_STB=2/T_REC=1 instance; outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_sja1000_bus_master;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sja1000_bus_master_if bus();
    sja1000_bus_master_if pbus();

    // Emulated SJA1000 read data: valid on AD only while RDn is low.
    logic [7:0] rd_val = 8'h00;
    assign bus.sja_ad_in  = bus.sja_rdn  ? 8'hEE : rd_val;
    assign pbus.sja_ad_in = pbus.sja_rdn ? 8'hEE : rd_val;

    sja1000_bus_master dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    sja1000_bus_master #(.T_STB(2), .T_REC(1)) dut_p (.clk(clk), .rst_n(rst_n), .bus(pbus));

    int n_assert   = 0;
    int n_fail     = 0;
    int excl_viol  = 0;

    always @(negedge clk) begin
        if ((bus.sja_ale && !bus.sja_csn) || (!bus.sja_wrn && !bus.sja_rdn) ||
            (pbus.sja_ale && !pbus.sja_csn) || (!pbus.sja_wrn && !pbus.sja_rdn))
            excl_viol <= excl_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {busy, done, ale, csn, wrn, rdn, oe, ad[7:0]}
    function automatic logic [14:0] pk(input logic b, input logic d, input logic ale,
                                       input logic csn, input logic wrn, input logic rdn,
                                       input logic oe, input logic [7:0] ad);
        return {b, d, ale, csn, wrn, rdn, oe, ad};
    endfunction

    // Expected pins k falling edges after the request edge, default timing.
    function automatic logic [14:0] exp_phase(input int k, input logic wr,
                                              input logic [7:0] addr, input logic [7:0] wdata);
        if (k <= 2)       return pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, addr);
        else if (k == 3)  return pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, addr);
        else if (k <= 7)  return wr ? pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, wdata)
                                    : pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        else if (k == 8)  return wr ? pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, wdata)
                                    : pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        else if (k <= 10) return pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        else              return pk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    endfunction

    // AD is only compared while the expected output enable is set.
    task automatic check_bus(input string tag, input logic [14:0] exp);
        logic [14:0] obs;
        obs = pk(bus.busy, bus.done, bus.sja_ale, bus.sja_csn, bus.sja_wrn, bus.sja_rdn,
                 bus.sja_ad_oe, bus.sja_ad_out);
        if (!exp[8]) obs[7:0] = 8'h00;
        check(tag, {17'd0, obs}, {17'd0, exp});
    endtask

    // One transfer on the default instance, checked cycle by cycle through done.
    task automatic run_seq(input string tag, input logic wr, input logic [7:0] addr,
                           input logic [7:0] wdata);
        bus.req = 1'b1; bus.req_wr = wr; bus.req_addr = addr; bus.req_wdata = wdata;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            bus.req = 1'b0;
            check_bus($sformatf("%s_c%0d", tag, k), exp_phase(k, wr, addr, wdata));
        end
    endtask

    initial begin
        int d1, d2, dn, ale_n, ale2, ad2, ff_n, bz, wl, cl;
        logic prev_ale;
        bus.req = 1'b0;  bus.req_wr = 1'b0;  bus.req_addr = 8'h00;  bus.req_wdata = 8'h00;
        bus.sja_intn = 1'b1;
        pbus.req = 1'b0; pbus.req_wr = 1'b0; pbus.req_addr = 8'h00; pbus.req_wdata = 8'h00;
        pbus.sja_intn = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_bus("reset_pins", pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00));
        check("reset_ad", {24'd0, bus.sja_ad_out}, 32'h00);
        check("reset_rdata", {24'd0, bus.rdata}, 32'h00);
        check("reset_int", {31'd0, bus.int_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write cycle, then read cycle
        run_seq("wr", 1'b1, 8'h04, 8'hA5);
        check("wr_rdata_kept", {24'd0, bus.rdata}, 32'h00);
        @(negedge clk);
        rd_val = 8'h3C;
        run_seq("rd", 1'b0, 8'h02, 8'h00);
        check("rd_rdata", {24'd0, bus.rdata}, 32'h3C);

        // Back-to-back: req held high across the done cycle
        @(negedge clk);
        rd_val = 8'h5A;
        bus.req = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'h10; bus.req_wdata = 8'h66;
        d1 = 0; d2 = 0; dn = 0; ale_n = 0; ale2 = 0; ad2 = 0; prev_ale = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1)  begin bus.req_wr = 1'b0; bus.req_addr = 8'h11; end
            if (k == 12) bus.req = 1'b0;
            if (bus.done) begin dn++; if (d1 == 0) d1 = k; else d2 = k; end
            if (bus.sja_ale && !prev_ale) begin
                ale_n++;
                if (ale_n == 2) begin ale2 = k; ad2 = int'(bus.sja_ad_out); end
            end
            prev_ale = bus.sja_ale;
        end
        check("b2b_done_count", dn, 2);
        check("b2b_first_done", d1, 11);
        check("b2b_ale_after_done", ale2, d1 + 1);
        check("b2b_second_addr", ad2, 32'h11);
        // 10 cycles between the pulses, i.e. 11 edges from pulse to pulse
        check("b2b_done_spacing", d2 - d1, 11);
        check("b2b_rdata", {24'd0, bus.rdata}, 32'h5A);

        // Request during STB of another transfer is ignored
        @(negedge clk);
        bus.req = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'h01; bus.req_wdata = 8'h77;
        dn = 0; ale_n = 0; ff_n = 0; prev_ale = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) bus.req = 1'b0;
            if (k == 5) begin bus.req = 1'b1; bus.req_addr = 8'hFF; end
            if (k == 6) bus.req = 1'b0;
            if (bus.done) dn++;
            if (bus.sja_ale && !prev_ale) begin
                ale_n++;
                if (bus.sja_ad_out == 8'hFF) ff_n++;
            end
            prev_ale = bus.sja_ale;
        end
        check("ign_ale_count", ale_n, 1);
        check("ign_ff_cycles", ff_n, 0);
        check("ign_done_count", dn, 1);
        check("ign_rdata_kept", {24'd0, bus.rdata}, 32'h5A);

        // Reset in the middle of a write strobe
        bus.req = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'h30; bus.req_wdata = 8'h11;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
        check("rst_in_stb", {31'd0, bus.sja_wrn}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_bus("rst_async", pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00));
        check("rst_async_ad", {24'd0, bus.sja_ad_out}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0; bz = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (bus.done) dn++;
            if (bus.busy) bz++;
        end
        check("rst_no_done", dn, 0);
        check("rst_no_busy", bz, 0);
        run_seq("post_rst", 1'b1, 8'h20, 8'hC3);

        // Interrupt synchroniser: two edges each way
        @(negedge clk);
        bus.sja_intn = 1'b0;
        @(posedge clk); #1;
        check("int_assert_1edge", {31'd0, bus.int_o}, 32'd0);
        @(posedge clk); #1;
        check("int_assert_2edge", {31'd0, bus.int_o}, 32'd1);
        @(negedge clk);
        bus.sja_intn = 1'b1;
        @(posedge clk); #1;
        check("int_release_1edge", {31'd0, bus.int_o}, 32'd1);
        @(posedge clk); #1;
        check("int_release_2edge", {31'd0, bus.int_o}, 32'd0);

        // Overridden timing: T_STB=2, T_REC=1
        @(negedge clk);
        pbus.req = 1'b1; pbus.req_wr = 1'b1; pbus.req_addr = 8'h40; pbus.req_wdata = 8'h99;
        dn = 0; bz = 0; wl = 0; cl = 0; d1 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            pbus.req = 1'b0;
            if (pbus.busy) bz++;
            if (!pbus.sja_wrn) wl++;
            if (!pbus.sja_csn) cl++;
            if (pbus.done) begin dn++; d1 = k; end
        end
        check("par_busy_len", bz, 7);
        check("par_strobe_len", wl, 2);
        check("par_csn_len", cl, 3);
        check("par_done_count", dn, 1);
        check("par_done_cycle", d1, 8);
        rd_val = 8'hC7;
        pbus.req = 1'b1; pbus.req_wr = 1'b0; pbus.req_addr = 8'h41;
        dn = 0; wl = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            pbus.req = 1'b0;
            if (!pbus.sja_rdn) wl++;
            if (pbus.done) dn++;
        end
        check("par_rd_strobe_len", wl, 2);
        check("par_rd_done", dn, 1);
        check("par_rd_rdata", {24'd0, pbus.rdata}, 32'hC7);

        check("strobe_exclusive", excl_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
